// File: rtl/fc_argmax_pkg.sv
// rtl/fc_argmax_pkg.sv - shared FC defines: state encoding and default sizes
package fc_argmax_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } fc_state_t;

   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_NUM_CLASSES = 10;
   localparam int DEF_IDX_WIDTH   = 4;

   // Counter must reach NUM_CLASSES itself, so size for n+1 values
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/fc_argmax_if.sv
// rtl/fc_argmax_if.sv - node stream and classification result bundle
interface fc_argmax_if
   import fc_argmax_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int IDX_WIDTH  = DEF_IDX_WIDTH
);

   logic                  enable;
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;
   logic                  finished;
   logic [IDX_WIDTH-1:0]  result;

   modport master (
      output enable,
      output in_valid,
      output in_data,
      input  in_ready,
      input  finished,
      input  result
   );

   modport slave (
      input  enable,
      input  in_valid,
      input  in_data,
      output in_ready,
      output finished,
      output result
   );

endinterface

// File: rtl/fc_signed_cmp.sv
// rtl/fc_signed_cmp.sv - combinational two's-complement greater-than
module fc_signed_cmp #(
   parameter int DATA_WIDTH = 16
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  gt
);

   assign gt = $signed(a) > $signed(b);

endmodule

// File: rtl/fc_argmax.sv
// rtl/fc_argmax.sv - running argmax over one streamed final-layer vector
module fc_argmax
   import fc_argmax_pkg::*;
#(
   parameter int NUM_CLASSES = DEF_NUM_CLASSES,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int IDX_WIDTH   = DEF_IDX_WIDTH
) (
   input  logic        clk,
   input  logic        reset,
   fc_argmax_if.slave  bus
);

   localparam int CNT_WIDTH = cnt_width(NUM_CLASSES);

   fc_state_t             state;
   fc_state_t             state_nxt;
   logic [CNT_WIDTH-1:0]  count;
   logic [DATA_WIDTH-1:0] max_val;
   logic [IDX_WIDTH-1:0]  max_idx;
   logic [IDX_WIDTH-1:0]  result_q;
   logic                  seen;
   logic                  gt;
   logic                  start;
   logic                  accept;
   logic                  last;
   logic                  take;
   logic [IDX_WIDTH-1:0]  cand_idx;
   logic [IDX_WIDTH-1:0]  win_idx;

   fc_signed_cmp #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_cmp (
      .a  (bus.in_data),
      .b  (max_val),
      .gt (gt)
   );

   assign cand_idx = IDX_WIDTH'(count);
   assign last     = (count == CNT_WIDTH'(NUM_CLASSES - 1));
   // Strict compare keeps the lower index on ties
   assign take     = accept && (!seen || gt);
   assign win_idx  = take ? cand_idx : max_idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      start        = 1'b0;
      accept       = 1'b0;
      bus.in_ready = 1'b0;
      bus.finished = 1'b0;
      case (state)
         IDLE: begin
            if (bus.enable) begin
               state_nxt = ACCUM;
               start     = 1'b1;
            end
         end
         ACCUM: begin
            bus.in_ready = 1'b1;
            // Abort wins over a sample arriving on the same cycle
            if (!bus.enable) begin
               state_nxt = IDLE;
            end else if (bus.in_valid) begin
               accept = 1'b1;
               if (last) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            bus.finished = 1'b1;
            if (!bus.enable) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count    <= '0;
         max_val  <= '0;
         max_idx  <= '0;
         result_q <= '0;
         seen     <= 1'b0;
      end else if (start) begin
         count   <= '0;
         max_val <= '0;
         max_idx <= '0;
         seen    <= 1'b0;
      end else if (accept) begin
         count <= count + 1'b1;
         seen  <= 1'b1;
         if (take) begin
            max_val <= bus.in_data;
            max_idx <= cand_idx;
         end
         if (last) begin
            result_q <= win_idx;
         end
      end
   end

   assign bus.result = result_q;

endmodule

// File: tb/tb_fc_argmax.sv
// tb/tb_fc_argmax.sv - randomized bench for fc_argmax against an array argmax model
module tb_fc_argmax;
   import fc_argmax_pkg::*;

   localparam int NC = 10;
   localparam int DW = 16;
   localparam int IW = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fc_argmax_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

   fc_argmax #(
      .NUM_CLASSES (NC),
      .DATA_WIDTH  (DW),
      .IDX_WIDTH   (IW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int            vectors     = 0;
   int            miscompares = 0;
   int            last_result = 0;
   logic [DW-1:0] vals [NC];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
      vectors++;
      if (obs !== expd) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expd);
      end
   endtask

   task automatic check_outs(input string tag, input int rdy, input int fin, input int res);
      check({tag, "_ready"},    32'(bus.in_ready), 32'(rdy));
      check({tag, "_finished"}, 32'(bus.finished), 32'(fin));
      check({tag, "_result"},   32'(bus.result),   32'(res));
   endtask

   // First index holding the largest signed value
   function automatic int ref_argmax();
      int best = 0;
      for (int i = 1; i < NC; i++) begin
         if ($signed(vals[i]) > $signed(vals[best])) best = i;
      end
      return best;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic start_run(input string tag);
      bus.enable   = 1'b1;
      bus.in_valid = 1'b0;
      tick();
      check_outs({tag, "_start"}, 1, 0, last_result);
   endtask

   // mode 0: back-to-back, 1: stall before every sample, 2: random stalls
   task automatic stream(input string tag, input int mode);
      int expd;
      int stalls;
      expd = ref_argmax();
      for (int i = 0; i < NC; i++) begin
         stalls = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
         for (int s = 0; s < stalls; s++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = DW'($urandom);
            tick();
            check_outs({tag, "_stall"}, 1, 0, last_result);
         end
         bus.in_valid = 1'b1;
         bus.in_data  = vals[i];
         tick();
         if (i < NC - 1) check_outs({tag, "_acc"}, 1, 0, last_result);
         else            check_outs({tag, "_done"}, 0, 1, expd);
      end
      last_result  = expd;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h7fff;
      tick();
      check_outs({tag, "_hold"}, 0, 1, expd);
      bus.in_valid = 1'b0;
   endtask

   task automatic release_run(input string tag);
      bus.enable   = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      check_outs({tag, "_release"}, 0, 0, last_result);
   endtask

   initial begin
      int tp1 [NC] = '{3, -1, 7, 2, 7, 0, -5, 1, 6, 4};

      reset        = 1'b1;
      bus.enable   = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      tick();
      tick();
      check_outs("reset", 0, 0, 0);
      reset = 1'b0;
      tick();
      check_outs("idle", 0, 0, 0);

      for (int i = 0; i < NC; i++) vals[i] = DW'(tp1[i]);
      start_run("tp1");
      stream("tp1", 0);
      check("tp1_fixed", 32'(bus.result), 32'd2);
      release_run("tp1");

      for (int i = 0; i < NC; i++) vals[i] = DW'(-100);
      vals[9] = DW'(-99);
      start_run("tp2");
      stream("tp2", 1);
      check("tp2_fixed", 32'(bus.result), 32'd9);
      release_run("tp2");

      for (int i = 0; i < NC; i++) vals[i] = 16'h8000;
      vals[0] = 16'h7fff;
      start_run("tp3");
      stream("tp3", 0);
      check("tp3_fixed", 32'(bus.result), 32'd0);
      release_run("tp3");

      start_run("abort");
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = (i == 1) ? DW'(1000) : DW'(i);
         tick();
         check_outs("abort_acc", 1, 0, last_result);
      end
      bus.enable   = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(5000);
      tick();
      check_outs("abort_drop", 0, 0, last_result);
      for (int c = 0; c < 3; c++) begin
         bus.in_valid = 1'(($urandom));
         tick();
         check_outs("abort_idle", 0, 0, last_result);
      end
      for (int i = 0; i < NC; i++) vals[i] = DW'(int'($urandom_range(0, 100)) - 50);
      vals[8] = DW'(100);
      start_run("tp4");
      stream("tp4", 2);
      check("tp4_fixed", 32'(bus.result), 32'd8);
      release_run("tp4");

      for (int i = 0; i < NC; i++) vals[i] = DW'(i);
      vals[5] = DW'(2000);
      start_run("tp5");
      stream("tp5", 0);
      check("tp5_fixed", 32'(bus.result), 32'd5);
      reset = 1'b1;
      tick();
      check_outs("rst_done", 0, 0, 0);
      reset       = 1'b0;
      bus.enable  = 1'b0;
      last_result = 0;
      tick();
      check_outs("rst_done_idle", 0, 0, 0);

      start_run("tp6");
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = DW'(3000 + i);
         tick();
      end
      reset        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(9000);
      tick();
      check_outs("rst_accum", 0, 0, 0);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      check_outs("rst_restart", 1, 0, 0);
      for (int i = 0; i < NC; i++) vals[i] = DW'($urandom);
      stream("tp6", 0);
      release_run("tp6");

      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < NC; i++) begin
            if ($urandom_range(0, 1) == 0) vals[i] = DW'($urandom);
            else                           vals[i] = DW'(int'($urandom_range(0, 6)) - 3);
         end
         start_run("rnd");
         stream("rnd", int'($urandom_range(0, 2)));
         release_run("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
